// File: rtl/perm_theta_if.sv
// Handshake bundle carrying one Keccak state into and out of the theta step.
// The slave side is the theta block; the master side is the producer/consumer pair.
interface perm_theta_if #(
  parameter int X_AXIS = 5,
  parameter int Y_AXIS = 5,
  parameter int Z_AXIS = 64
);
  logic                                        in_valid;
  logic                                        in_ready;
  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]   a_theta_in;
  logic                                        out_valid;
  logic                                        out_ready;
  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]   a_theta_out;

  modport slave (
    input  in_valid, a_theta_in, out_ready,
    output in_ready, out_valid, a_theta_out
  );

  modport master (
    output in_valid, a_theta_in, out_ready,
    input  in_ready, out_valid, a_theta_out
  );
endinterface

// File: rtl/perm_theta.sv
// Keccak-f[1600] theta step as a two-stage valid/ready pipeline: column parities are
// registered with the state in the first stage, the parity mask is applied in the second.
module perm_theta #(
  parameter int X_AXIS = 5,
  parameter int Y_AXIS = 5,
  parameter int Z_AXIS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  perm_theta_if.slave bus
);

  typedef logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] state_t;
  typedef logic [X_AXIS-1:0][Z_AXIS-1:0]             plane_t;

  function automatic plane_t col_parity(input state_t a);
    plane_t c;
    c = '0;
    for (int x = 0; x < X_AXIS; x++)
      for (int y = 0; y < Y_AXIS; y++)
        c[x] = c[x] ^ a[x][y];
    return c;
  endfunction

  // Neighbour columns: x-1 unshifted, x+1 taken one bit lower in z (z=0 wraps to the top bit).
  function automatic state_t theta_mix(input state_t a, input plane_t c);
    state_t r;
    logic   d;
    r = '0;
    for (int x = 0; x < X_AXIS; x++)
      for (int z = 0; z < Z_AXIS; z++) begin
        d = c[(x + X_AXIS - 1) % X_AXIS][z] ^
            c[(x + 1) % X_AXIS][(z + Z_AXIS - 1) % Z_AXIS];
        for (int y = 0; y < Y_AXIS; y++)
          r[x][y][z] = a[x][y][z] ^ d;
      end
    return r;
  endfunction

  state_t state_p1;
  plane_t par_p1;
  logic   vld_p1;
  state_t out_p2;
  logic   vld_p2;

  logic   s2_adv;
  logic   in_ready;
  logic   accept;

  assign s2_adv   = vld_p1 && (!vld_p2 || bus.out_ready);
  assign in_ready = !vld_p1 || s2_adv;
  assign accept   = bus.in_valid && in_ready;

  // Stage 1: capture state and its column parities
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      state_p1 <= '0;
      par_p1   <= '0;
    end else begin
      vld_p1 <= accept || (vld_p1 && !s2_adv);
      if (accept) begin
        state_p1 <= bus.a_theta_in;
        par_p1   <= col_parity(bus.a_theta_in);
      end
    end
  end

  // Stage 2: apply theta mask, hold result until downstream takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      out_p2 <= '0;
    end else begin
      vld_p2 <= s2_adv || (vld_p2 && !bus.out_ready);
      if (s2_adv)
        out_p2 <= theta_mix(state_p1, par_p1);
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = vld_p2;
  assign bus.a_theta_out = out_p2;

endmodule

// File: tb/tb_perm_theta.sv
// Directed bench for perm_theta: lane-word reference model, scoreboard on every
// output handshake, plus literal expectations for single-bit and z-wrap states.
module tb_perm_theta;

  localparam int Z = 64;
  typedef logic [4:0][4:0][Z-1:0] state_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  perm_theta_if #(.X_AXIS(5), .Y_AXIS(5), .Z_AXIS(Z)) bus ();

  perm_theta #(.X_AXIS(5), .Y_AXIS(5), .Z_AXIS(Z)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference theta on 64-bit lanes: D[x] = C[x-1] ^ rotl(C[x+1], 1)
  function automatic state_t theta_model(input state_t a);
    logic [Z-1:0] c [5];
    logic [Z-1:0] d [5];
    state_t r;
    for (int x = 0; x < 5; x++)
      c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
    for (int x = 0; x < 5; x++)
      d[x] = c[(x + 4) % 5] ^ ((c[(x + 1) % 5] << 1) | (c[(x + 1) % 5] >> (Z - 1)));
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = a[x][y] ^ d[x];
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input state_t act, input state_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          if (act[x][y] !== exp[x][y]) begin
            $display("FAIL %s: lane[%0d][%0d] got %h expected %h", name, x, y, act[x][y], exp[x][y]);
            return;
          end
    end
  endtask

  // Scoreboard: handshakes are sampled on the falling edge, i.e. what the next rising edge sees.
  state_t exp_q [$];
  state_t hold_val;
  logic   have_hold = 1'b0;
  logic   prev_xfer = 1'b0;
  int     run_len = 0;
  int     max_run = 0;
  int     acc_cnt = 0;
  int     out_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      have_hold = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (bus.out_valid && have_hold)
        chk_state("hold_stable", bus.a_theta_out, hold_val);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0)
          chk_int("unexpected_output", 1, 0);
        else
          chk_state("scoreboard", bus.a_theta_out, exp_q.pop_front());
        out_cnt++;
        run_len   = prev_xfer ? run_len + 1 : 1;
        if (run_len > max_run) max_run = run_len;
        prev_xfer = 1'b1;
        have_hold = 1'b0;
      end else begin
        prev_xfer = 1'b0;
        if (bus.out_valid) begin
          have_hold = 1'b1;
          hold_val  = bus.a_theta_out;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(theta_model(bus.a_theta_in));
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input state_t s);
    bus.a_theta_in = s;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready) begin
        step();
        bus.in_valid = 1'b0;
        return;
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk_int("send_timeout", 1, 0);
  endtask

  task automatic wait_out(output state_t o);
    o = '0;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) begin
        o = bus.a_theta_out;
        step();
        return;
      end
      step();
    end
    chk_int("output_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  state_t e1, e2, s1, s2, got;
  int     acc0, out0;

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a_theta_in = '0;
    bus.out_ready  = 1'b0;
    repeat (3) step();
    chk_int("rst_out_valid", int'(bus.out_valid), 0);
    chk_state("rst_out_data", bus.a_theta_out, '0);

    // Literal expectations that pin the reference model
    s1 = '0; s1[0][0][0] = 1'b1;
    e1 = '0; e1[0][0][0] = 1'b1;
    for (int y = 0; y < 5; y++) begin e1[1][y][0] = 1'b1; e1[4][y][1] = 1'b1; end
    s2 = '0; s2[1][0][Z-1] = 1'b1;
    e2 = '0; e2[1][0][Z-1] = 1'b1;
    for (int y = 0; y < 5; y++) begin e2[2][y][Z-1] = 1'b1; e2[0][y][0] = 1'b1; end
    chk_state("model_single_bit", theta_model(s1), e1);
    chk_state("model_z_wrap", theta_model(s2), e2);
    chk_state("model_zero", theta_model('0), '0);

    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk_int("in_ready_after_reset", int'(bus.in_ready), 1);

    // Zero state and latency
    bus.a_theta_in = '0;
    bus.in_valid   = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk_int("lat_after_accept", int'(bus.out_valid), 0);
    step();
    chk_int("lat_two_cycles", int'(bus.out_valid), 1);
    chk_state("zero_out", bus.a_theta_out, '0);
    step();
    chk_int("lat_single_pulse", int'(bus.out_valid), 0);

    // Single-bit and z-wrap states
    send(s1);
    wait_out(got);
    chk_state("single_bit", got, e1);
    chk_int("single_bit_ones", $countones(got), 11);
    send(s2);
    wait_out(got);
    chk_state("z_wrap", got, e2);
    chk_int("z_wrap_ones", $countones(got), 11);

    // Streaming: 8 back-to-back states
    out0    = out_cnt;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      bus.a_theta_in = rand_state();
      bus.in_valid   = 1'b1;
      chk_int("stream_in_ready", int'(bus.in_ready), 1);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk_int("stream_count", out_cnt - out0, 8);
    chk_int("stream_consecutive", max_run, 8);

    // Backpressure: at most two states held
    bus.out_ready = 1'b0;
    acc0 = acc_cnt;
    out0 = out_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.a_theta_in = rand_state();
      bus.in_valid   = 1'b1;
      step();
    end
    chk_int("bp_accepts", acc_cnt - acc0, 2);
    chk_int("bp_in_ready_low", int'(bus.in_ready), 0);
    chk_int("bp_out_valid", int'(bus.out_valid), 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    chk_int("bp_drained", out_cnt - out0, 2);
    chk_int("bp_queue_empty", exp_q.size(), 0);

    // Reset with two states in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.a_theta_in = rand_state();
      bus.in_valid   = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    chk_int("pre_reset_full", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    step();
    chk_int("midrst_out_valid", int'(bus.out_valid), 0);
    chk_state("midrst_out_data", bus.a_theta_out, '0);
    rst_n = 1'b1;
    chk_int("midrst_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    out0 = out_cnt;
    s1 = rand_state();
    send(s1);
    chk_int("post_rst_lat1", int'(bus.out_valid), 0);
    step();
    chk_int("post_rst_lat2", int'(bus.out_valid), 1);
    chk_state("post_rst_data", bus.a_theta_out, theta_model(s1));
    repeat (3) step();
    chk_int("post_rst_count", out_cnt - out0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
